// File: rtl/fir_mac_sequencer.sv
// ----------------------------------------------------------------------------
// fir_mac_sequencer
//   Time-multiplexed FIR controller. A single shared signed multiplier-
//   accumulator walks every tap of the delay line once per accepted sample,
//   replacing TAP_NUMBER parallel multipliers. Holds the delay line and a
//   coefficient bank that can be rewritten at runtime while idle.
//
//   Optional feature macro: FIR_SAT_EN
//     defined   : data_out is the accumulator saturated to the signed output
//                 range; sat_flag marks a clipped result.
//     undefined : data_out is the low output bits of the accumulator (wrap);
//                 sat_flag is always 0.
//
// Ports
//   clk         in   clock, all state on posedge
//   rst         in   synchronous active-high reset
//   in_valid    in   data_in valid
//   in_ready    out  block can accept a sample (IDLE only)
//   data_in     in   signed sample, DATA_WIDTH
//   coef_we     in   coefficient write strobe (honoured in IDLE only)
//   coef_addr   in   tap index to write
//   coef_wdata  in   signed coefficient value
//   out_valid   out  data_out valid
//   out_ready   in   downstream accepts data_out
//   data_out    out  signed filter result, DATA_WIDTH+COEF_WIDTH
//   sat_flag    out  result was clipped (FIR_SAT_EN builds only)
//   busy        out  state is not IDLE
// ----------------------------------------------------------------------------
module fir_mac_sequencer #(
    parameter int  DATA_WIDTH = 16,
    parameter int  COEF_WIDTH = 16,
    parameter int  TAP_NUMBER = 4,
    parameter int  ACC_WIDTH  = 34,
    localparam int TW         = $clog2(TAP_NUMBER),
    localparam int OW         = DATA_WIDTH + COEF_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         coef_we,
    input  logic [TW-1:0]                coef_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OW-1:0]         data_out,
    output logic                         sat_flag,
    output logic                         busy
);

`ifdef FIR_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] sr_q   [TAP_NUMBER];
    logic signed [COEF_WIDTH-1:0] coef_q [TAP_NUMBER];
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic [TW-1:0]                idx_q;
    logic signed [OW-1:0]         data_out_q;
    logic                         sat_q;

    logic                         accept;
    logic                         coef_ok;
    logic                         last_tap;
    logic signed [OW-1:0]         mul_a;
    logic signed [OW-1:0]         mul_b;
    logic signed [OW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic                         ovf;
    logic signed [OW-1:0]         res;

    assign accept   = (state_q == StIdle) && in_valid;
    assign coef_ok  = coef_we && (state_q == StIdle) && (int'({1'b0, coef_addr}) < TAP_NUMBER);
    assign last_tap = (idx_q == TW'(TAP_NUMBER - 1));

    // Operands sign-extended to the full product width so the OW-bit product
    // is the exact signed result.
    assign mul_a   = {{COEF_WIDTH{sr_q[idx_q][DATA_WIDTH-1]}}, sr_q[idx_q]};
    assign mul_b   = {{DATA_WIDTH{coef_q[idx_q][COEF_WIDTH-1]}}, coef_q[idx_q]};
    assign prod    = mul_a * mul_b;
    assign acc_sum = acc_q + {{(ACC_WIDTH-OW){prod[OW-1]}}, prod};

    // Out of range when the bits above the output sign bit disagree with it.
    always_comb begin
        ovf = (acc_sum[ACC_WIDTH-1:OW-1] != {(ACC_WIDTH-OW+1){acc_sum[ACC_WIDTH-1]}});
        res = acc_sum[OW-1:0];
        if (SatEn && ovf) begin
            res = acc_sum[ACC_WIDTH-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = StMac;
            end
            StMac: begin
                if (last_tap) state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAP_NUMBER; i++) begin
                sr_q[i]   <= '0;
                coef_q[i] <= COEF_WIDTH'((TAP_NUMBER - i) << 8);
            end
            acc_q      <= '0;
            idx_q      <= '0;
            data_out_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            // Applied before the MAC starts, so a write in the accepting cycle
            // is already visible to that sample.
            if (coef_ok) coef_q[coef_addr] <= coef_wdata;
            if (accept) begin
                for (int i = TAP_NUMBER - 1; i > 0; i--) sr_q[i] <= sr_q[i-1];
                sr_q[0] <= data_in;
                acc_q   <= '0;
                idx_q   <= '0;
            end else if (state_q == StMac) begin
                acc_q <= acc_sum;
                idx_q <= last_tap ? '0 : idx_q + 1'b1;
                if (last_tap) begin
                    data_out_q <= res;
                    sat_q      <= SatEn && ovf;
                end
            end
        end
    end

    assign data_out = data_out_q;
    assign sat_flag = sat_q;

endmodule
